// File: rtl/ex_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_iter
// Purpose  : Iterative multiply/divide engine beside the EX-stage ALU.
//            Handles MULTU, MULT, DIVU and DIV. It uses shift-add for
//            multiply and restoring division for divide, retiring one bit
//            per cycle. The result is a {hi,lo} pair for the HI/LO write
//            path.
// Ports    :
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start_i      operation request, sampled only while idle
//   op_i         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   opa_i        multiplicand / dividend
//   opb_i        multiplier / divisor
//   annul_i      abort the current or the requested operation
//   busy_o       engine not idle
//   stall_req_o  pipeline stall request (combinational)
//   done_o       one-cycle result-valid pulse
//   hi_o         product high half / remainder
//   lo_o         product low half / quotient
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              stall_req_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_div;
  logic [2*DATA_W-1:0] r_acc;     // mult: {upper, multiplier}; div: {rem, quot}
  logic [DATA_W-1:0]   r_opd;     // multiplicand or divisor magnitude
  logic                r_sign_q;  // product sign or quotient sign
  logic                r_sign_r;  // remainder sign (dividend sign)
  logic                r_done;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  // Request decode and operand magnitudes
  logic              w_req;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic              w_div0;

  assign w_req   = start_i & ~annul_i;
  assign w_a_neg = op_i[0] & opa_i[DATA_W-1];
  assign w_b_neg = op_i[0] & opb_i[DATA_W-1];
  // The most-negative value negates to itself, which is exactly its
  // unsigned magnitude 2^(DATA_W-1).
  assign w_a_mag = w_a_neg ? -opa_i : opa_i;
  assign w_b_mag = w_b_neg ? -opb_i : opb_i;
  assign w_div0  = op_i[1] & (opb_i == '0);

  // Multiply step: conditional add into the upper half, then shift right
  // with the carry moving into the top bit.
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_nxt;

  assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                   + {1'b0, (r_acc[0] ? r_opd : {DATA_W{1'b0}})};
  assign w_mul_nxt = {w_mul_sum, r_acc[DATA_W-1:1]};

  // Divide step: shift {rem,quot} left, then trial-subtract at DATA_W+1 bits.
  // The remainder is always below the divisor, so the shifted value is below
  // twice the divisor and the top bit of the difference is a true sign.
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_trial;
  logic [2*DATA_W-1:0] w_div_nxt;

  assign w_rem_sh  = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_trial   = w_rem_sh - {1'b0, r_opd};
  assign w_div_nxt = w_trial[DATA_W]
                   ? {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                   : {w_trial[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b1};

  logic [2*DATA_W-1:0] w_acc_nxt;
  assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;

  // Sign correction applied on the final step's value
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_quot_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  logic [DATA_W-1:0]   w_fin_hi;
  logic [DATA_W-1:0]   w_fin_lo;

  assign w_prod_fix = r_sign_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quot     = w_acc_nxt[DATA_W-1:0];
  assign w_rem      = w_acc_nxt[2*DATA_W-1:DATA_W];
  assign w_quot_fix = r_sign_q ? -w_quot : w_quot;
  assign w_rem_fix  = r_sign_r ? -w_rem  : w_rem;
  assign w_fin_hi   = r_is_div ? w_rem_fix  : w_prod_fix[2*DATA_W-1:DATA_W];
  assign w_fin_lo   = r_is_div ? w_quot_fix : w_prod_fix[DATA_W-1:0];

  logic w_last;
  assign w_last = (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_opd    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_is_div <= op_i[1];
            r_cnt    <= '0;
            r_sign_q <= w_a_neg ^ w_b_neg;
            r_sign_r <= w_a_neg;
            r_opd    <= op_i[1] ? w_b_mag : w_a_mag;
            r_acc    <= op_i[1] ? {{DATA_W{1'b0}}, w_a_mag}
                                : {{DATA_W{1'b0}}, w_b_mag};
            if (w_div0) begin
              // Divide by zero: dividend passes through untouched.
              r_hi    <= opa_i;
              r_lo    <= '1;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_hi    <= w_fin_hi;
              r_lo    <= w_fin_lo;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign stall_req_o = (r_state == S_CALC) | ((r_state == S_IDLE) & w_req);
  // An annul arriving in the FIN cycle suppresses the result pulse.
  assign done_o      = r_done & ~annul_i;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_iter
// Purpose  : Self-checking bench for ex_muldiv_iter. It uses directed corner
//            cases and randomized operations checked against a plain
//            arithmetic reference model. It also covers annul, reset and
//            latency behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_iter;

  localparam int c_W = 32;
  // Request cycle to done cycle, counted in clock edges
  localparam int c_LAT      = c_W + 1;
  localparam int c_LAT_DIV0 = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_i = 1'b0;
  logic [1:0]     op_i = 2'b00;
  logic [c_W-1:0] opa_i = '0;
  logic [c_W-1:0] opb_i = '0;
  logic           annul_i = 1'b0;
  logic           busy_o;
  logic           stall_req_o;
  logic           done_o;
  logic [c_W-1:0] hi_o;
  logic [c_W-1:0] lo_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_muldiv_iter #(.DATA_W(c_W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .opa_i       (opa_i),
    .opb_i       (opb_i),
    .annul_i     (annul_i),
    .busy_o      (busy_o),
    .stall_req_o (stall_req_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on wide integers
  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = {32'h0, a} * {32'h0, b};
      2'b01: begin p = sa * sb; res = 64'(p); end
      2'b10: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation and wait (bounded) for done. Returns at the
  // negedge inside the done cycle without advancing past it.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit scramble,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output int cyc, output int stalls,
                       output bit fin_stall, output bit ok);
    @(negedge clk);
    op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
    stalls = 0; cyc = 0; ok = 1'b0; hi = '0; lo = '0; fin_stall = 1'b0;
    #1;
    if (stall_req_o) stalls++;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      if (done_o) begin
        start_i   = 1'b0;
        ok        = 1'b1;
        hi        = hi_o;
        lo        = lo_o;
        #1;
        fin_stall = stall_req_o;
        break;
      end
      if (stall_req_o) stalls++;
      if (scramble) begin
        opa_i   = $urandom;
        opb_i   = $urandom;
        op_i    = 2'($urandom_range(0, 3));
        start_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done_o); end
    n_cmp++; if (hi_o !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi_o); end
    n_cmp++; if (lo_o !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo_o); end
    n_cmp++; if (stall_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall_req_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed vectors with hand-derived results
  logic [1:0]  d_op [6] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b10};
  logic [31:0] d_a  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5};
  logic [31:0] d_b  [6] = '{32'h3, 32'h3, 32'h2, 32'd7, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] d_hi [6] = '{32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'd5};
  logic [31:0] d_lo [6] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF};

  task automatic test_directed();
    logic [31:0] hi, lo;
    int cyc, stalls, lat;
    bit fs, ok;
    for (int i = 0; i < 6; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], 1'b0, hi, lo, cyc, stalls, fs, ok);
      lat = (d_b[i] == 32'h0) ? c_LAT_DIV0 : c_LAT;
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL dir%0d_timeout no done within %0d edges", i, cyc); end
      n_cmp++; if (hi !== d_hi[i]) begin n_bad++; $display("FAIL dir%0d_hi got %h want %h", i, hi, d_hi[i]); end
      n_cmp++; if (lo !== d_lo[i]) begin n_bad++; $display("FAIL dir%0d_lo got %h want %h", i, lo, d_lo[i]); end
      n_cmp++; if (cyc !== lat) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, cyc, lat); end
      n_cmp++; if (stalls !== lat) begin n_bad++; $display("FAIL dir%0d_stall_cycles got %0d want %0d", i, stalls, lat); end
      n_cmp++; if (fs !== 1'b0) begin n_bad++; $display("FAIL dir%0d_fin_stall got %0b want 0", i, fs); end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b, hi, lo;
    logic [1:0]  op;
    logic [63:0] exp;
    int cyc, stalls, lat;
    bit fs, ok;
    for (int i = 0; i < n; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = pick_operand();
      b   = pick_operand();
      exp = model(op, a, b);
      lat = (op[1] && b == 32'h0) ? c_LAT_DIV0 : c_LAT;
      do_op(op, a, b, 1'(i % 2), hi, lo, cyc, stalls, fs, ok);
      n_cmp++;
      if (!ok || hi !== exp[63:32] || lo !== exp[31:0] || cyc !== lat) begin
        n_bad++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                 i, op, a, b, hi, lo, cyc, exp[63:32], exp[31:0], lat);
      end
    end
  endtask

  task automatic test_annul_calc();
    logic [31:0] hi, lo;
    logic [63:0] prior;
    int cyc, stalls;
    bit fs, ok, seen;
    prior = model(2'b00, 32'h1234_5678, 32'h0000_0010);
    do_op(2'b00, 32'h1234_5678, 32'h0000_0010, 1'b0, hi, lo, cyc, stalls, fs, ok);
    @(negedge clk);
    op_i = 2'b01; opa_i = 32'h7654_3210; opb_i = 32'hDEAD_BEEF; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL annul_calc_busy got %0b want 0", busy_o); end
    seen = 1'b0;
    repeat (40) begin
      if (done_o) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL annul_calc_done got pulse want none"); end
    n_cmp++; if (hi_o !== prior[63:32]) begin n_bad++; $display("FAIL annul_calc_hi got %h want %h", hi_o, prior[63:32]); end
    n_cmp++; if (lo_o !== prior[31:0]) begin n_bad++; $display("FAIL annul_calc_lo got %h want %h", lo_o, prior[31:0]); end
  endtask

  task automatic test_annul_fin();
    logic [31:0] hi, lo;
    int cyc, stalls;
    bit fs, ok;
    do_op(2'b10, 32'd1000, 32'd3, 1'b0, hi, lo, cyc, stalls, fs, ok);
    annul_i = 1'b1;
    #1;
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL annul_fin_done got %0b want 0", done_o); end
    @(negedge clk);
    annul_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL annul_fin_busy got %0b want 0", busy_o); end
  endtask

  task automatic test_annul_idle();
    bit seen;
    @(negedge clk);
    op_i = 2'b00; opa_i = 32'd9; opb_i = 32'd9; start_i = 1'b1; annul_i = 1'b1;
    #1;
    n_cmp++; if (stall_req_o !== 1'b0) begin n_bad++; $display("FAIL annul_idle_stall got %0b want 0", stall_req_o); end
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL annul_idle_busy got %0b want 0", busy_o); end
    start_i = 1'b0; annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (done_o) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL annul_idle_done got pulse want none"); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    int cyc, stalls;
    bit fs, ok;
    do_op(2'b01, 32'hFFFF_FFFE, 32'h3, 1'b0, hi, lo, cyc, stalls, fs, ok);
    @(negedge clk);
    op_i = 2'b00; opa_i = 32'hABCD_0123; opb_i = 32'h0F0F_0F0F; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %0b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %0b want 0", done_o); end
    n_cmp++; if (hi_o !== 32'h0) begin n_bad++; $display("FAIL rstmid_hi got %h want 0", hi_o); end
    n_cmp++; if (lo_o !== 32'h0) begin n_bad++; $display("FAIL rstmid_lo got %h want 0", lo_o); end
    @(negedge clk);
    rst = 1'b0;
    do_op(2'b10, 32'd100, 32'd7, 1'b0, hi, lo, cyc, stalls, fs, ok);
    n_cmp++; if (!ok || hi !== 32'd2 || lo !== 32'd14) begin
      n_bad++; $display("FAIL rstmid_after got hi=%h lo=%h want hi=2 lo=e", hi, lo);
    end
  endtask

  // Consecutive operations with no idle gap beyond the mandatory one
  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    logic [63:0] exp;
    int cyc, stalls;
    bit fs, ok;
    for (int i = 0; i < 4; i++) begin
      exp = model(2'(i), 32'h8000_0000 + 32'(i), 32'hFFFF_FFF0 - 32'(i));
      do_op(2'(i), 32'h8000_0000 + 32'(i), 32'hFFFF_FFF0 - 32'(i), 1'b1, hi, lo, cyc, stalls, fs, ok);
      n_cmp++; if (!ok || hi !== exp[63:32] || lo !== exp[31:0]) begin
        n_bad++; $display("FAIL b2b%0d got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_annul_calc();
    test_annul_fin();
    test_annul_idle();
    test_reset_mid();
    test_back_to_back();
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
